// File: rtl/encap_ekey_lookup_pkg.sv
// Shared widths, bucket field positions and FSM encoding for the encap ekey lookup client.
// Bucket layout from MSB: valid, key, ignored middle bits, then the value pointer in the low bits.
package encap_ekey_lookup_pkg;

  localparam int EEKEY_DEPTH_NBITS       = 10;
  localparam int EEKEY_KEY_NBITS         = 48;
  localparam int EEKEY_VALUE_DEPTH_NBITS = 10;
  localparam int EEKEY_BUCKET_NBITS      = 59;
  localparam int EEKEY_VALUE_NBITS       = 272;
  localparam int EEKEY_CNT_NBITS         = 32;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_HT_WAIT  = 3'd1,
    ST_CMP      = 3'd2,
    ST_VAL_WAIT = 3'd3,
    ST_RESP     = 3'd4
  } lookup_state_t;

  function automatic int bucket_valid_bit(input int bucket_nbits);
    return bucket_nbits - 1;
  endfunction

  function automatic int bucket_key_msb(input int bucket_nbits);
    return bucket_nbits - 2;
  endfunction

endpackage

// File: rtl/encap_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear takes priority over increment.
module encap_sat_cnt #(
  parameter int CNT_NBITS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 inc,
  output logic [CNT_NBITS-1:0] cnt
);

  localparam logic [CNT_NBITS-1:0] ONE = {{(CNT_NBITS-1){1'b0}}, 1'b1};

  // count register: clear wins, then saturating increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + ONE;
    end else begin
      cnt <= cnt;
    end
  end

endmodule

// File: rtl/encap_ekey_lookup.sv
// Exact-match lookup of an encap key in the two-way ekey hash table, followed by a read of
// the matching value record; every memory read is ack-qualified because latency varies.
module encap_ekey_lookup
  import encap_ekey_lookup_pkg::*;
#(
  parameter int DEPTH_NBITS       = EEKEY_DEPTH_NBITS,
  parameter int KEY_NBITS         = EEKEY_KEY_NBITS,
  parameter int VALUE_DEPTH_NBITS = EEKEY_VALUE_DEPTH_NBITS,
  parameter int BUCKET_NBITS      = EEKEY_BUCKET_NBITS,
  parameter int VALUE_NBITS       = EEKEY_VALUE_NBITS,
  parameter int CNT_NBITS         = EEKEY_CNT_NBITS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         lookup_req,
  input  logic [KEY_NBITS-1:0]         lookup_key,
  input  logic [DEPTH_NBITS-1:0]       lookup_hash0,
  input  logic [DEPTH_NBITS-1:0]       lookup_hash1,
  output logic                         lookup_rdy,
  output logic                         lookup_ack,
  output logic                         lookup_hit,
  output logic [VALUE_DEPTH_NBITS-1:0] lookup_vptr,
  output logic [VALUE_NBITS-1:0]       lookup_value,
  output logic                         ekey_hash_table0_rd,
  output logic [DEPTH_NBITS-1:0]       ekey_hash_table0_raddr,
  input  logic                         ekey_hash_table0_ack,
  input  logic [BUCKET_NBITS-1:0]      ekey_hash_table0_rdata,
  output logic                         ekey_hash_table1_rd,
  output logic [DEPTH_NBITS-1:0]       ekey_hash_table1_raddr,
  input  logic                         ekey_hash_table1_ack,
  input  logic [BUCKET_NBITS-1:0]      ekey_hash_table1_rdata,
  output logic                         ekey_value_rd,
  output logic [VALUE_DEPTH_NBITS-1:0] ekey_value_raddr,
  input  logic                         ekey_value_ack,
  input  logic [VALUE_NBITS-1:0]       ekey_value_rdata,
  input  logic                         cnt_clr,
  output logic [CNT_NBITS-1:0]         hit_cnt,
  output logic [CNT_NBITS-1:0]         miss_cnt
);

  localparam int VALID_BIT = bucket_valid_bit(BUCKET_NBITS);
  localparam int KEY_MSB   = bucket_key_msb(BUCKET_NBITS);

  lookup_state_t                state_r;
  lookup_state_t                state_s;
  logic [KEY_NBITS-1:0]         key_r;
  logic [BUCKET_NBITS-1:0]      bkt0_r;
  logic [BUCKET_NBITS-1:0]      bkt1_r;
  logic                         done0_r;
  logic                         done1_r;
  logic [VALUE_DEPTH_NBITS-1:0] vptr_r;
  logic                         accept_s;
  logic                         ht_done_s;
  logic                         hit0_s;
  logic                         hit1_s;
  logic                         cmp_hit_s;
  logic [VALUE_DEPTH_NBITS-1:0] cmp_vptr_s;
  logic                         inc_hit_s;
  logic                         inc_miss_s;

  assign lookup_rdy = (state_r == ST_IDLE);
  assign accept_s   = lookup_req & lookup_rdy;

  // bucket compare; way 0 wins when both ways hold the key
  always_comb begin
    hit0_s     = bkt0_r[VALID_BIT] && (bkt0_r[KEY_MSB -: KEY_NBITS] == key_r);
    hit1_s     = bkt1_r[VALID_BIT] && (bkt1_r[KEY_MSB -: KEY_NBITS] == key_r);
    cmp_hit_s  = hit0_s | hit1_s;
    if (hit0_s) begin
      cmp_vptr_s = bkt0_r[VALUE_DEPTH_NBITS-1:0];
    end else begin
      cmp_vptr_s = bkt1_r[VALUE_DEPTH_NBITS-1:0];
    end
  end

  // next-state logic; an arriving ack counts as done in the cycle it arrives
  always_comb begin
    state_s   = state_r;
    ht_done_s = (done0_r | ekey_hash_table0_ack) & (done1_r | ekey_hash_table1_ack);
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_s = ST_HT_WAIT;
        else          state_s = ST_IDLE;
      end
      ST_HT_WAIT: begin
        if (ht_done_s) state_s = ST_CMP;
        else           state_s = ST_HT_WAIT;
      end
      ST_CMP: begin
        if (cmp_hit_s) state_s = ST_VAL_WAIT;
        else           state_s = ST_RESP;
      end
      ST_VAL_WAIT: begin
        if (ekey_value_ack) state_s = ST_RESP;
        else                state_s = ST_VAL_WAIT;
      end
      ST_RESP: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_s;
  end

  // request latch and hash-table read strobes, issued once in the first HT_WAIT cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_r                  <= '0;
      ekey_hash_table0_rd    <= 1'b0;
      ekey_hash_table1_rd    <= 1'b0;
      ekey_hash_table0_raddr <= '0;
      ekey_hash_table1_raddr <= '0;
    end else begin
      ekey_hash_table0_rd <= accept_s;
      ekey_hash_table1_rd <= accept_s;
      if (accept_s) begin
        key_r                  <= lookup_key;
        ekey_hash_table0_raddr <= lookup_hash0;
        ekey_hash_table1_raddr <= lookup_hash1;
      end
    end
  end

  // per-way bucket capture; acks outside HT_WAIT are dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bkt0_r  <= '0;
      bkt1_r  <= '0;
      done0_r <= 1'b0;
      done1_r <= 1'b0;
    end else if (accept_s) begin
      done0_r <= 1'b0;
      done1_r <= 1'b0;
    end else if (state_r == ST_HT_WAIT) begin
      if (ekey_hash_table0_ack) begin
        bkt0_r  <= ekey_hash_table0_rdata;
        done0_r <= 1'b1;
      end
      if (ekey_hash_table1_ack) begin
        bkt1_r  <= ekey_hash_table1_rdata;
        done1_r <= 1'b1;
      end
    end
  end

  // value read strobe, issued once in the first VAL_WAIT cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ekey_value_rd    <= 1'b0;
      ekey_value_raddr <= '0;
      vptr_r           <= '0;
    end else begin
      ekey_value_rd <= (state_r == ST_CMP) && cmp_hit_s;
      if ((state_r == ST_CMP) && cmp_hit_s) begin
        ekey_value_raddr <= cmp_vptr_s;
        vptr_r           <= cmp_vptr_s;
      end
    end
  end

  // response registers; data fields hold until the next response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lookup_ack   <= 1'b0;
      lookup_hit   <= 1'b0;
      lookup_vptr  <= '0;
      lookup_value <= '0;
    end else begin
      lookup_ack <= (state_s == ST_RESP);
      if ((state_r == ST_CMP) && !cmp_hit_s) begin
        lookup_hit   <= 1'b0;
        lookup_vptr  <= '0;
        lookup_value <= '0;
      end else if ((state_r == ST_VAL_WAIT) && ekey_value_ack) begin
        lookup_hit   <= 1'b1;
        lookup_vptr  <= vptr_r;
        lookup_value <= ekey_value_rdata;
      end
    end
  end

  assign inc_hit_s  = (state_r == ST_RESP) &  lookup_hit;
  assign inc_miss_s = (state_r == ST_RESP) & ~lookup_hit;

  encap_sat_cnt #(.CNT_NBITS(CNT_NBITS)) u_hit_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (inc_hit_s),
    .cnt (hit_cnt)
  );

  encap_sat_cnt #(.CNT_NBITS(CNT_NBITS)) u_miss_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (inc_miss_s),
    .cnt (miss_cnt)
  );

endmodule

// File: doc/encap_ekey_lookup.md
# encap_ekey_lookup

- Client of the encap ekey memory block: performs exact-match lookup of an encap key against the two-way ekey hash table, then reads the matching ekey value record.
- Sits between the encap key/hash generator upstream and the ekey memory block's application read ports (hash table 0/1, value).
- Memory read latency is variable because PIO accesses arbitrate against application reads, so every memory read is ack-qualified.
- Also keeps hit/miss statistics.

## Interface

- DEPTH_NBITS, 10, hash table address width per way
- KEY_NBITS, 48, encap key width
- VALUE_DEPTH_NBITS, 10, value memory address width
- BUCKET_NBITS, 59, bucket width; must be ≥ 1+KEY_NBITS+VALUE_DEPTH_NBITS
- VALUE_NBITS, 272, value record width
- CNT_NBITS, 32, statistics counter width

Ports:

- clk  in  1  clock; the block has one clock
- `RESET_SIG  in  1  asynchronous, active-high reset
- lookup_req  in  1  lookup request; accepted when lookup_req & lookup_rdy
- lookup_key  in  KEY_NBITS  key to match
- lookup_hash0  in  DEPTH_NBITS  way-0 bucket index
- lookup_hash1  in  DEPTH_NBITS  way-1 bucket index
- lookup_rdy  out  1  block is idle and can accept a request
- lookup_ack  out  1  one-cycle response pulse
- lookup_hit  out  1  key found (valid with lookup_ack)
- lookup_vptr  out  VALUE_DEPTH_NBITS  value pointer of the hit entry
- lookup_value  out  VALUE_NBITS  value record on a hit; 0 on a miss
- ekey_hash_table0_rd / ekey_hash_table1_rd  out  1  one-cycle read strobes
- ekey_hash_table0_raddr / ekey_hash_table1_raddr  out  DEPTH_NBITS  read addresses
- ekey_hash_table0_ack / ekey_hash_table1_ack  in  1  read data valid
- ekey_hash_table0_rdata / ekey_hash_table1_rdata  in  BUCKET_NBITS  bucket contents
- ekey_value_rd  out  1  value read strobe
- ekey_value_raddr  out  VALUE_DEPTH_NBITS  value read address
- ekey_value_ack  in  1  value data valid
- ekey_value_rdata  in  VALUE_NBITS  value record
- cnt_clr  in  1  synchronous clear of both statistics counters
- hit_cnt / miss_cnt  out  CNT_NBITS  saturating statistics counters

## Operation

**Bucket fields**

- valid = bit BUCKET_NBITS-1
- key = bits [BUCKET_NBITS-2 -: KEY_NBITS]
- vptr = bits [VALUE_DEPTH_NBITS-1:0]
- Remaining middle bits are ignored.

**FSM states:** IDLE, HT_WAIT, CMP, VAL_WAIT, RESP. lookup_rdy = (state == IDLE), combinational.

- **IDLE:** on accept, latch key and both hashes; go to HT_WAIT.
- **HT_WAIT:**
  - First cycle: ht0_rd and ht1_rd are both 1, with raddr set to the latched hashes.
  - Each ack captures its rdata into a per-way holding register and sets a done flag. The two acks may arrive in any order or in the same cycle.
  - When both done flags are set (including the just-arriving ack), go to CMP.
- **CMP:**
  - hitN = validN & (keyN == latched key).
  - If both ways hit, way 0 wins.
  - Hit: latch vptr, go to VAL_WAIT.
  - Miss: go to RESP with hit=0, vptr=0, value=0.
- **VAL_WAIT:**
  - First cycle: value_rd = 1, raddr = vptr.
  - On ekey_value_ack: latch rdata, go to RESP with hit=1.
- **RESP:** lookup_ack = 1 for exactly one cycle; go to IDLE.
- An ack outside its wait state is ignored; no state or data change.
- A read strobe is never reissued while its ack is pending.
- Counters:
  - hit_cnt or miss_cnt increments in the RESP cycle and saturates at all-ones.
  - cnt_clr in the same cycle as an increment: the counter becomes 0 (clear wins).

## Timing

- All outputs are registered except lookup_rdy.
- Reset values:
  - All outputs 0, except lookup_rdy = 1.
  - State = IDLE; holding registers and flags cleared.
- Reset asserted mid-lookup aborts it: no lookup_ack is issued and any later acks are ignored.
- For a request accepted at edge T, with minimum memory latency (ack in the cycle after rd):
  - Read strobes in cycle T+1.
  - Acks in cycle T+2.
  - CMP in cycle T+3.
  - Miss: lookup_ack in cycle T+4.
  - Hit: value_rd in cycle T+4, value ack in cycle T+5, lookup_ack in cycle T+6.
- Each additional ack delay adds cycles one-for-one.
- lookup_rdy returns to 1 in the cycle after lookup_ack. Back-to-back request throughput: one miss per 5 cycles, one hit per 7 cycles.
- lookup_hit, lookup_vptr and lookup_value are valid only while lookup_ack = 1. They hold their values until the next response.

## Structure

- Constants go in defines.vh: EEKEY_* widths and the bucket field-position macros (EEKEY_BUCKET_VALID_BIT, EEKEY_BUCKET_KEY_RANGE, EEKEY_BUCKET_VPTR_RANGE). These are shared with the software table writer and the ekey memory block.
- One sub-module, encap_sat_cnt: a CNT_NBITS saturating counter with increment and clear, instantiated twice.

## Test plan

- Way-0 hit: bucket0 = {1, key 0x0000_1234_5678, vptr 5}, value[5] = 0xA5-pattern; both acks at latency 1 -> lookup_ack at T+6, hit=1, vptr=5, value=pattern; hit_cnt=1.
- Way-1-only hit with ack1 arriving 4 cycles before ack0 -> value_rd issued at raddr = way-1 vptr exactly once; hit=1.
- Both ways hit, vptr0=3, vptr1=9 -> value_raddr=3.
- Miss: bucket0 key differs; bucket1 matches but valid=0 -> lookup_ack at T+4, hit=0, value=0, no value_rd; miss_cnt=1.
- Spurious ekey_value_ack in IDLE, then a reset pulse while in VAL_WAIT -> no lookup_ack, lookup_rdy=1, counters=0.
- Counter preloaded near all-ones, then misses -> miss_cnt saturates at 0xFFFF_FFFF; cnt_clr in the same cycle as a RESP -> counter reads 0.
